// File: rtl/jk_cmd_pkg.sv
// Shared types and constants for the JK command debouncer:
// FSM state encoding, J/K command codes and the counter-width helper.
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, debounce counter and a one-cycle
// press pulse on the rising edge of the debounced level.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             sync1;
  logic             sync2;
  logic             stable_prev;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      count       <= '0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      stable_prev <= stable;
      // Any return to the stable level restarts the qualification run.
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign press = stable & ~stable_prev;

endmodule

// File: rtl/jk_cmd_debouncer.sv
// Debounces SET/CLEAR buttons, pairs near-simultaneous presses and emits
// one-cycle registered J/K command pulses (10 set, 01 reset, 11 toggle).
module jk_cmd_debouncer
  import jk_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PAIR_WINDOW     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_clr,
  output logic J,
  output logic K,
  output logic cmd_valid,
  output logic set_stable,
  output logic clr_stable
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, PAIR_WINDOW);

  logic             press_set;
  logic             press_clr;
  state_t           state;
  logic [1:0]       rec_code;
  logic [CNT_W-1:0] win;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_set),
    .stable (set_stable),
    .press  (press_set)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk    (clk),
    .reset  (reset),
    .raw    (btn_clr),
    .stable (clr_stable),
    .press  (press_clr)
  );

  // J/K/cmd_valid are loaded only on the transition into EMIT, so they are
  // nonzero exactly while the state is EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rec_code  <= JK_HOLD;
      win       <= '0;
      J         <= 1'b0;
      K         <= 1'b0;
      cmd_valid <= 1'b0;
    end else begin
      J         <= 1'b0;
      K         <= 1'b0;
      cmd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (press_set && press_clr) begin
            state     <= EMIT;
            {J, K}    <= JK_TOGGLE;
            cmd_valid <= 1'b1;
          end else if (press_set || press_clr) begin
            state    <= WAIT;
            rec_code <= press_set ? JK_SET : JK_RESET;
            win      <= '0;
          end
        end
        WAIT: begin
          if ((rec_code == JK_SET && press_clr) || (rec_code == JK_RESET && press_set)) begin
            state     <= EMIT;
            {J, K}    <= JK_TOGGLE;
            cmd_valid <= 1'b1;
          end else if (win == CNT_W'(PAIR_WINDOW - 1)) begin
            // Emitted even if the recorded button was released meanwhile.
            state     <= EMIT;
            {J, K}    <= rec_code;
            cmd_valid <= 1'b1;
          end else begin
            win <= win + CNT_W'(1);
          end
        end
        EMIT: state <= HOLD;
        HOLD: begin
          if (!set_stable && !clr_stable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_debouncer.sv
// Directed bench for jk_cmd_debouncer (DEBOUNCE_CYCLES=4, PAIR_WINDOW=3)
// with an expected-command queue consumed by a separate monitor.
module tb_jk_cmd_debouncer;
  import jk_cmd_pkg::*;

  localparam int DB = 4;
  localparam int PW = 3;
  localparam int LAT_STABLE = DB + 2;
  localparam int LAT_SINGLE = LAT_STABLE + PW + 1;
  localparam int LAT_PAIR   = LAT_STABLE + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_set = 1'b0;
  logic btn_clr = 1'b0;
  logic J, K, cmd_valid, set_stable, clr_stable;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];

  jk_cmd_debouncer #(.DEBOUNCE_CYCLES(DB), .PAIR_WINDOW(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_set    (btn_set),
    .btn_clr    (btn_clr),
    .J          (J),
    .K          (K),
    .cmd_valid  (cmd_valid),
    .set_stable (set_stable),
    .clr_stable (clr_stable)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_cmd(input logic [1:0] code, input int at_cycle);
    exp_q.push_back(code);
    exp_cyc_q.push_back(at_cycle);
  endtask

  // Monitor: pops the scoreboard on every command pulse
  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", {27'd0, J, K, cmd_valid, set_stable, clr_stable}, 32'd0);
    end else if (cmd_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", {30'd0, J, K}, 32'd0);
      end else begin
        check("cmd_code", {30'd0, J, K}, {30'd0, exp_q.pop_front()});
        check("cmd_cycle", cyc, exp_cyc_q.pop_front());
      end
    end else begin
      check("jk_idle", {30'd0, J, K}, 32'd0);
    end
  end

  initial begin
    int n;
    // 1: reset with both buttons held, then a toggle after release
    btn_set = 1'b1;
    btn_clr = 1'b1;
    step(3);
    reset = 1'b0;
    n = cyc;
    expect_cmd(JK_TOGGLE, n + LAT_PAIR);
    step(LAT_STABLE - 1);
    check("t1_set_stable_early", {31'd0, set_stable}, 32'd0);
    step(1);
    check("t1_set_stable", {31'd0, set_stable}, 32'd1);
    check("t1_clr_stable", {31'd0, clr_stable}, 32'd1);
    step(10);
    btn_set = 1'b0;
    btn_clr = 1'b0;
    step(12);

    // 2: clean SET press held 30 cycles, single pulse
    btn_set = 1'b1;
    n = cyc;
    expect_cmd(JK_SET, n + LAT_SINGLE);
    step(LAT_STABLE - 1);
    check("t2_set_stable_early", {31'd0, set_stable}, 32'd0);
    step(1);
    check("t2_set_stable", {31'd0, set_stable}, 32'd1);
    step(30 - LAT_STABLE);
    btn_set = 1'b0;
    step(12);
    check("t2_set_released", {31'd0, set_stable}, 32'd0);

    // 3: bouncing CLEAR never qualifies
    for (int i = 0; i < 3; i++) begin
      btn_clr = 1'b1;
      step(2);
      check("t3_clr_stable_hi", {31'd0, clr_stable}, 32'd0);
      btn_clr = 1'b0;
      step(2);
      check("t3_clr_stable_lo", {31'd0, clr_stable}, 32'd0);
    end
    step(12);
    check("t3_clr_stable_end", {31'd0, clr_stable}, 32'd0);

    // 4: SET then CLEAR two cycles later pairs into one toggle
    btn_set = 1'b1;
    n = cyc;
    expect_cmd(JK_TOGGLE, n + LAT_PAIR + 2);
    step(2);
    btn_clr = 1'b1;
    step(20);
    btn_set = 1'b0;
    btn_clr = 1'b0;
    step(12);
    check("t4_state_idle", {30'd0, dut.state}, {30'd0, IDLE});

    // 5: CLEAR held, SET pressed during HOLD is ignored
    btn_clr = 1'b1;
    n = cyc;
    expect_cmd(JK_RESET, n + LAT_SINGLE);
    step(LAT_STABLE + 10);
    btn_set = 1'b1;
    step(15);
    check("t5_state_hold", {30'd0, dut.state}, {30'd0, HOLD});
    btn_set = 1'b0;
    btn_clr = 1'b0;
    step(12);
    btn_set = 1'b1;
    n = cyc;
    expect_cmd(JK_SET, n + LAT_SINGLE);
    step(20);
    btn_set = 1'b0;
    step(12);

    // 6: reset during WAIT aborts; held button re-qualifies after reset
    btn_set = 1'b1;
    step(LAT_STABLE + 2);
    check("t6_state_wait", {30'd0, dut.state}, {30'd0, WAIT});
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n = cyc;
    expect_cmd(JK_SET, n + LAT_SINGLE);
    step(20);
    btn_set = 1'b0;
    step(12);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
